// File: rtl/signal_lamp_sequencer.sv
// Three-road signal lamp sequencer: RED/GREEN/YELLOW per road, fixed priority MR1>MR2>MR3, shared all-red clearance.
// Optional conflict monitor (flashing-yellow fault mode) compiled in with macro CONFLICT_MON_EN.
module signal_lamp_sequencer #(
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic green_req_MR1,
  input  logic green_req_MR2,
  input  logic green_req_MR3,
  output logic red_MR1,
  output logic yellow_MR1,
  output logic green_MR1,
  output logic red_MR2,
  output logic yellow_MR2,
  output logic green_MR2,
  output logic red_MR3,
  output logic yellow_MR3,
  output logic green_MR3,
  output logic fault
);

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } road_e;

  localparam logic [3:0] YEL_LAST = 4'(YELLOW_TICKS - 1);
  localparam logic [3:0] AR_LOAD  = 4'(ALL_RED_TICKS);

  road_e      state_q [3];
  road_e      state_d [3];
  logic [3:0] ycnt_q  [3];
  logic [3:0] ycnt_d  [3];
  logic [3:0] ar_cnt_q, ar_cnt_d;

  logic [2:0] req;
  logic [2:0] elig;
  logic [2:0] grant;
  logic [2:0] is_green;
  logic [2:0] is_yellow;
  logic [2:0] is_red;
  logic       all_red;
  logic       y2r;

  assign req = {green_req_MR3, green_req_MR2, green_req_MR1};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      is_red[i]    = (state_q[i] == ST_RED);
      is_green[i]  = (state_q[i] == ST_GREEN);
      is_yellow[i] = (state_q[i] == ST_YELLOW);
    end
  end

  assign all_red = &is_red;
  assign elig    = req & {3{all_red && (ar_cnt_q == 4'd0)}};
  assign grant   = {elig[2] & ~elig[1] & ~elig[0], elig[1] & ~elig[0], elig[0]};

`ifdef CONFLICT_MON_EN
  logic fault_q, fault_d;
  logic flash_q, flash_d;
  logic conflict;

  assign conflict = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]) |
                    (is_green[0] & is_green[1]) | (is_green[0] & is_green[2]) |
                    (is_green[1] & is_green[2]);
  assign fault_d  = fault_q | conflict;
  // Flash phase starts at 0 on fault entry and toggles per tick thereafter.
  assign flash_d  = fault_q ? (flash_q ^ tick) : 1'b0;
`endif

  always_comb begin
    y2r      = 1'b0;
    ar_cnt_d = ar_cnt_q;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      ycnt_d[i]  = ycnt_q[i];
      case (state_q[i])
        ST_RED: begin
          if (grant[i]) state_d[i] = ST_GREEN;
        end
        ST_GREEN: begin
          if (!req[i]) begin
            state_d[i] = ST_YELLOW;
            ycnt_d[i]  = 4'd0;
          end
        end
        ST_YELLOW: begin
          if (tick) begin
            if (ycnt_q[i] == YEL_LAST) begin
              state_d[i] = ST_RED;
              ycnt_d[i]  = 4'd0;
              y2r        = 1'b1;
            end else begin
              ycnt_d[i] = ycnt_q[i] + 4'd1;
            end
          end
        end
        default: begin
          state_d[i] = ST_RED;
          ycnt_d[i]  = 4'd0;
        end
      endcase
    end

    if (y2r) ar_cnt_d = AR_LOAD;
    else if (tick && (ar_cnt_q != 4'd0)) ar_cnt_d = ar_cnt_q - 4'd1;

`ifdef CONFLICT_MON_EN
    if (fault_d) begin
      for (int i = 0; i < 3; i++) begin
        state_d[i] = ST_RED;
        ycnt_d[i]  = 4'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_RED;
        ycnt_q[i]  <= 4'd0;
      end
      ar_cnt_q <= AR_LOAD;
`ifdef CONFLICT_MON_EN
      fault_q  <= 1'b0;
      flash_q  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        ycnt_q[i]  <= ycnt_d[i];
      end
      ar_cnt_q <= ar_cnt_d;
`ifdef CONFLICT_MON_EN
      fault_q  <= fault_d;
      flash_q  <= flash_d;
`endif
    end
  end

  logic [2:0] lamp_r, lamp_y, lamp_g;

`ifdef CONFLICT_MON_EN
  always_comb begin
    lamp_r = is_red;
    lamp_y = is_yellow;
    lamp_g = is_green;
    if (fault_q) begin
      lamp_r = 3'b000;
      lamp_y = {3{flash_q}};
      lamp_g = 3'b000;
    end
  end
  assign fault = fault_q;
`else
  assign lamp_r = is_red;
  assign lamp_y = is_yellow;
  assign lamp_g = is_green;
  assign fault  = 1'b0;
`endif

  assign {red_MR3, red_MR2, red_MR1}          = lamp_r;
  assign {yellow_MR3, yellow_MR2, yellow_MR1} = lamp_y;
  assign {green_MR3, green_MR2, green_MR1}    = lamp_g;

endmodule

// File: tb/tb_signal_lamp_sequencer.sv
// Directed bench: instance A (YELLOW_TICKS=3, ALL_RED_TICKS=1), instance B (YELLOW_TICKS=2, ALL_RED_TICKS=0).
module tb_signal_lamp_sequencer;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
  logic b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;

  logic ra1, ya1, ga1, ra2, ya2, ga2, ra3, ya3, ga3, fa;
  logic rb1, yb1, gb1, rb2, yb2, gb2, rb3, yb3, gb3, fb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  signal_lamp_sequencer #(.YELLOW_TICKS(3), .ALL_RED_TICKS(1)) dut_a (
    .clk(clk), .reset(reset), .tick(tick),
    .green_req_MR1(r1), .green_req_MR2(r2), .green_req_MR3(r3),
    .red_MR1(ra1), .yellow_MR1(ya1), .green_MR1(ga1),
    .red_MR2(ra2), .yellow_MR2(ya2), .green_MR2(ga2),
    .red_MR3(ra3), .yellow_MR3(ya3), .green_MR3(ga3),
    .fault(fa)
  );

  signal_lamp_sequencer #(.YELLOW_TICKS(2), .ALL_RED_TICKS(0)) dut_b (
    .clk(clk), .reset(reset), .tick(tick),
    .green_req_MR1(b1), .green_req_MR2(b2), .green_req_MR3(b3),
    .red_MR1(rb1), .yellow_MR1(yb1), .green_MR1(gb1),
    .red_MR2(rb2), .yellow_MR2(yb2), .green_MR2(gb2),
    .red_MR3(rb3), .yellow_MR3(yb3), .green_MR3(gb3),
    .fault(fb)
  );

  wire [8:0] la = {ra1, ya1, ga1, ra2, ya2, ga2, ra3, ya3, ga3};
  wire [8:0] lb = {rb1, yb1, gb1, rb2, yb2, gb2, rb3, yb3, gb3};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    step();
    reset = 1'b0;
    check("reset_lamps", 32'(la), 32'({R, R, R}));
    check("reset_fault", 32'(fa), 32'd0);

    // MR1 waits for the post-reset all-red clearance tick
    r1 = 1'b1;
    step();
    check("ar_pending_0", 32'(la), 32'({R, R, R}));
    step();
    check("ar_pending_1", 32'(la), 32'({R, R, R}));
    tick_step();
    check("ar_tick_edge", 32'(la), 32'({R, R, R}));
    step();
    check("mr1_green", 32'(la), 32'({G, R, R}));

    r2 = 1'b1;
    step();
    check("mr2_blocked", 32'(la), 32'({G, R, R}));
    r1 = 1'b0;
    step();
    check("mr1_yellow", 32'(la), 32'({Y, R, R}));
    tick_step();
    check("mr1_y_t1", 32'(la), 32'({Y, R, R}));
    step();
    tick_step();
    check("mr1_y_t2", 32'(la), 32'({Y, R, R}));
    tick_step();
    check("mr1_red_t3", 32'(la), 32'({R, R, R}));
    step();
    check("mr2_wait_ar", 32'(la), 32'({R, R, R}));
    tick_step();
    check("mr2_ar_tick", 32'(la), 32'({R, R, R}));
    step();
    check("mr2_green", 32'(la), 32'({R, G, R}));

    // tick coincident with GREEN->YELLOW must not count
    r2 = 1'b0;
    tick_step();
    check("mr2_yellow", 32'(la), 32'({R, Y, R}));
    tick_step();
    tick_step();
    check("mr2_y_not_counted", 32'(la), 32'({R, Y, R}));
    tick_step();
    check("mr2_red", 32'(la), 32'({R, R, R}));
    tick_step();

`ifndef CONFLICT_MON_EN
    r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
    step();
    check("prio_mr1", 32'(la), 32'({G, R, R}));
    r1 = 1'b0;
    step();
    check("prio_mr1_yel", 32'(la), 32'({Y, R, R}));
    tick_step();
    r1 = 1'b1;
    step();
    check("reassert_no_abort", 32'(la), 32'({Y, R, R}));
    tick_step();
    tick_step();
    check("reassert_red", 32'(la), 32'({R, R, R}));
    step();
    tick_step();
    check("reassert_ar", 32'(la), 32'({R, R, R}));
    step();
    check("reassert_regrant", 32'(la), 32'({G, R, R}));
    r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
`endif

    // reset mid-yellow overrides tick and requests
    reset = 1'b1;
    step();
    reset = 1'b0;
    tick_step();
    r2 = 1'b1;
    step();
    check("rst_mr2_green", 32'(la), 32'({R, G, R}));
    r2 = 1'b0;
    step();
    tick_step();
    check("rst_mr2_yel", 32'(la), 32'({R, Y, R}));
    reset = 1'b1; tick = 1'b1; r1 = 1'b1;
    step();
    reset = 1'b0; tick = 1'b0;
    check("rst_all_red", 32'(la), 32'({R, R, R}));
    check("rst_fault", 32'(fa), 32'd0);
    step();
    step();
    check("rst_no_green", 32'(la), 32'({R, R, R}));
    tick_step();
    check("rst_ar_tick", 32'(la), 32'({R, R, R}));
    step();
    check("rst_then_green", 32'(la), 32'({G, R, R}));
    r1 = 1'b0;

    // MR1 and MR3 requested together for one clock
    reset = 1'b1;
    step();
    reset = 1'b0;
    tick_step();
    r1 = 1'b1; r3 = 1'b1;
    step();
    r1 = 1'b0; r3 = 1'b0;
`ifdef CONFLICT_MON_EN
    check("cf_fault", 32'(fa), 32'd1);
    check("cf_lamps0", 32'(la), 32'd0);
    step();
    check("cf_hold0", 32'(la), 32'd0);
    tick_step();
    check("cf_flash1", 32'(la), 32'({Y, Y, Y}));
    tick_step();
    check("cf_flash0", 32'(la), 32'd0);
    step();
    check("cf_fault_held", 32'(fa), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("cf_reset_lamps", 32'(la), 32'({R, R, R}));
    check("cf_reset_fault", 32'(fa), 32'd0);
`else
    check("cf_nomon_green", 32'(la), 32'({G, R, R}));
    check("cf_nomon_fault", 32'(fa), 32'd0);
    step();
    check("cf_nomon_yel", 32'(la), 32'({Y, R, R}));
`endif

    // zero all-red clearance on instance B
    reset = 1'b1;
    step();
    reset = 1'b0;
    b3 = 1'b1;
    step();
    check("b_mr3_green", 32'(lb), 32'({R, R, G}));
    b3 = 1'b0;
    step();
    check("b_mr3_yel", 32'(lb), 32'({R, R, Y}));
    b1 = 1'b1;
    step();
    check("b_mr1_blocked", 32'(lb), 32'({R, R, Y}));
    tick_step();
    check("b_y_t1", 32'(lb), 32'({R, R, Y}));
    tick_step();
    check("b_mr3_red", 32'(lb), 32'({R, R, R}));
    step();
    check("b_mr1_green", 32'(lb), 32'({G, R, R}));
    check("b_fault", 32'(fb), 32'd0);
    b1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
